// File: rtl/loader_pkg.sv
// Shared types and constants for the UART instruction-memory loader.
package loader_pkg;
   typedef enum logic [1:0] {
      COLLECT = 2'd0,
      WRITE   = 2'd1,
      DONE    = 2'd2,
      ERR     = 2'd3
   } loader_state_e;

   localparam logic [31:0] END_WORD_DEFAULT = 32'hFFFF_FFFF;
   localparam int          BYTE_IDX_W       = 2;
endpackage

// File: rtl/loader_word_asm.sv
// Little-endian byte-to-word assembler; word/word_complete present the finished word in the 4th-byte cycle.
module loader_word_asm
   import loader_pkg::*;
(
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  byte_en,
   input  logic                  clr,
   input  logic [7:0]            byte_in,
   output logic [BYTE_IDX_W-1:0] byte_idx,
   output logic [31:0]           word,
   output logic                  word_complete
);
   logic [31:0]           shift_q, shift_d;
   logic [BYTE_IDX_W-1:0] byte_idx_q, byte_idx_d;

   always_comb begin
      shift_d       = shift_q;
      byte_idx_d    = byte_idx_q;
      word_complete = 1'b0;
      // Newest byte enters at the top, so after four bytes the first sits in [7:0].
      word          = {byte_in, shift_q[31:8]};
      if (clr) begin
         byte_idx_d = '0;
      end else if (byte_en) begin
         shift_d       = {byte_in, shift_q[31:8]};
         byte_idx_d    = byte_idx_q + BYTE_IDX_W'(1);
         word_complete = (byte_idx_q == '1);
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) byte_idx_q <= '0;
      else         byte_idx_q <= byte_idx_d;
   end

   always_ff @(posedge clk) begin
      shift_q <= shift_d;
   end

   assign byte_idx = byte_idx_q;
endmodule

// File: rtl/uart_imem_loader.sv
// Loads 32-bit words received over UART into instruction memory, then releases the core.
// Optional inter-byte timeout enabled by defining LOADER_TIMEOUT_EN.
module uart_imem_loader
   import loader_pkg::*;
#(
   parameter int          ADDR_W      = 8,
   parameter logic [31:0] END_WORD    = END_WORD_DEFAULT,
   parameter int          TIMEOUT_CYC = 65535
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   input  logic              rx_break,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              cpu_rst,
   output logic              write_done,
   output logic              loader_err,
   output logic [ADDR_W:0]   word_count
);
   localparam logic [ADDR_W:0] MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};

   if (TIMEOUT_CYC < 1) begin : g_bad_timeout
      $error("TIMEOUT_CYC must be at least 1");
   end

   loader_state_e         state_q, state_d;
   logic [ADDR_W:0]       word_count_q, word_count_d;
   logic [ADDR_W-1:0]     imem_addr_q, imem_addr_d;
   logic [31:0]           imem_wdata_q, imem_wdata_d;
   logic                  active, byte_en, clr, timeout, word_complete;
   logic [31:0]           word;
   logic [BYTE_IDX_W-1:0] byte_idx;

   // A break always drops a coincident byte; only a non-empty partial word needs clearing.
   assign active  = (state_q == COLLECT) || (state_q == WRITE);
   assign byte_en = active && rx_valid && !rx_break;
   assign clr     = (active && rx_break && (byte_idx != '0)) || timeout;

   loader_word_asm u_word_asm (
      .clk           (clk),
      .resetn        (resetn),
      .byte_en       (byte_en),
      .clr           (clr),
      .byte_in       (rx_data),
      .byte_idx      (byte_idx),
      .word          (word),
      .word_complete (word_complete)
   );

`ifdef LOADER_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
   logic [CNT_W-1:0] idle_q, idle_d;

   always_comb begin
      idle_d  = idle_q;
      timeout = 1'b0;
      if (rx_valid || byte_idx == '0) begin
         idle_d = '0;
      end else if (state_q == COLLECT) begin
         idle_d = idle_q + CNT_W'(1);
         if (idle_q == CNT_W'(TIMEOUT_CYC - 1)) begin
            timeout = 1'b1;
            idle_d  = '0;
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) idle_q <= '0;
      else         idle_q <= idle_d;
   end
`else
   assign timeout = 1'b0;
`endif

   always_comb begin
      state_d      = state_q;
      word_count_d = word_count_q;
      imem_addr_d  = imem_addr_q;
      imem_wdata_d = imem_wdata_q;
      case (state_q)
         COLLECT: begin
            if (word_complete) begin
               if (word == END_WORD) begin
                  state_d = DONE;
               end else if (word_count_q == MAX_WORDS) begin
                  state_d = ERR;
               end else begin
                  state_d      = WRITE;
                  imem_addr_d  = word_count_q[ADDR_W-1:0];
                  imem_wdata_d = word;
               end
            end
         end
         WRITE: begin
            word_count_d = word_count_q + (ADDR_W+1)'(1);
            state_d      = COLLECT;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q      <= COLLECT;
         word_count_q <= '0;
         imem_addr_q  <= '0;
         imem_wdata_q <= '0;
      end else begin
         state_q      <= state_d;
         word_count_q <= word_count_d;
         imem_addr_q  <= imem_addr_d;
         imem_wdata_q <= imem_wdata_d;
      end
   end

   assign imem_we    = (state_q == WRITE);
   assign imem_addr  = imem_addr_q;
   assign imem_wdata = imem_wdata_q;
   assign cpu_rst    = (state_q != DONE);
   assign write_done = (state_q == DONE);
   assign loader_err = (state_q == ERR);
   assign word_count = word_count_q;
endmodule

// File: tb/tb_uart_imem_loader.sv
// Bench for uart_imem_loader: directed scenarios plus randomized byte streams against a word-level model.
module tb_uart_imem_loader;
   localparam int          ADDR_W = 2;
   localparam logic [31:0] ENDW   = 32'hFFFF_FFFF;
   localparam int          TMO    = 100;

   logic              clk = 1'b0;
   logic              resetn = 1'b0;
   logic              rx_valid = 1'b0;
   logic [7:0]        rx_data = 8'h00;
   logic              rx_break = 1'b0;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;
   logic              cpu_rst, write_done, loader_err;
   logic [ADDR_W:0]   word_count;

   uart_imem_loader #(.ADDR_W(ADDR_W), .END_WORD(ENDW), .TIMEOUT_CYC(TMO)) dut (
      .clk        (clk),
      .resetn     (resetn),
      .rx_valid   (rx_valid),
      .rx_data    (rx_data),
      .rx_break   (rx_break),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .cpu_rst    (cpu_rst),
      .write_done (write_done),
      .loader_err (loader_err),
      .word_count (word_count)
   );

   always #5 clk = ~clk;

   // Word-level model: bytes collected, words written, terminal outcome.
   logic        m_done, m_err, m_we;
   int          m_wc, m_nb, m_idle;
   logic [31:0] m_acc, m_addr, m_data;

   int vectors = 0;
   int errs    = 0;
   logic run = 1'b0;

   logic        lit_wr = 1'b0, lit_st = 1'b0, lit_wcc = 1'b0;
   logic [31:0] lit_addr, lit_data, lit_wc;
   logic        lit_done, lit_err, lit_rst;

   task automatic model_reset();
      m_done = 0; m_err = 0; m_we = 0; m_wc = 0; m_nb = 0; m_idle = 0;
      m_acc = 0; m_addr = 0; m_data = 0;
   endtask

   task automatic model_step(input logic v, input logic [7:0] d, input logic b);
      logic was_we;
      was_we = m_we;
      m_we   = 0;
      if (m_done || m_err) return;
      if (was_we) m_wc++;
`ifdef LOADER_TIMEOUT_EN
      if (v || m_nb == 0) m_idle = 0;
      else if (!was_we) begin
         m_idle++;
         if (m_idle == TMO) begin m_nb = 0; m_idle = 0; end
      end
`endif
      if (b) m_nb = 0;
      else if (v) begin
         m_acc[8*m_nb +: 8] = d;
         m_nb++;
         if (m_nb == 4) begin
            m_nb = 0;
            if (m_acc == ENDW) m_done = 1;
            else if (m_wc == (1 << ADDR_W)) m_err = 1;
            else begin m_we = 1; m_addr = m_wc; m_data = m_acc; end
         end
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (run) begin
         check("imem_we", 32'(imem_we), 32'(m_we));
         if (m_we) begin
            check("imem_addr", 32'(imem_addr), m_addr);
            check("imem_wdata", imem_wdata, m_data);
         end
         check("write_done", 32'(write_done), 32'(m_done));
         check("loader_err", 32'(loader_err), 32'(m_err));
         check("cpu_rst", 32'(cpu_rst), 32'(!m_done));
         check("word_count", 32'(word_count), m_wc);
         if (!resetn) begin
            check("rst_addr", 32'(imem_addr), 32'h0);
            check("rst_wdata", imem_wdata, 32'h0);
         end
         if (lit_wr) begin
            check("lit_we", 32'(imem_we), 32'h1);
            check("lit_addr", 32'(imem_addr), lit_addr);
            check("lit_wdata", imem_wdata, lit_data);
         end
         if (lit_st) begin
            check("lit_done", 32'(write_done), 32'(lit_done));
            check("lit_err", 32'(loader_err), 32'(lit_err));
            check("lit_cpu_rst", 32'(cpu_rst), 32'(lit_rst));
         end
         if (lit_wcc) check("lit_word_count", 32'(word_count), lit_wc);
      end
   end

   task automatic cycle(input logic v, input logic [7:0] d, input logic b);
      rx_valid = v; rx_data = d; rx_break = b;
      @(posedge clk);
      model_step(v, d, b);
      #1;
      rx_valid = 0; rx_break = 0;
   endtask

   task automatic do_reset();
      rx_valid = 0; rx_break = 0;
      resetn = 0;
      model_reset();
      @(negedge clk);
      @(posedge clk);
      #1 resetn = 1;
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int i = 0; i < 4; i++) cycle(1'b1, w[8*i +: 8], 1'b0);
   endtask

   task automatic expect_write(input logic [31:0] a, input logic [31:0] dta);
      lit_addr = a; lit_data = dta; lit_wr = 1;
      @(negedge clk); #1 lit_wr = 0;
   endtask

   task automatic expect_state(input logic dn, input logic er, input logic cr);
      lit_done = dn; lit_err = er; lit_rst = cr; lit_st = 1;
      @(negedge clk); #1 lit_st = 0;
   endtask

   task automatic expect_wc(input logic [31:0] n);
      lit_wc = n; lit_wcc = 1;
      @(negedge clk); #1 lit_wcc = 0;
   endtask

   initial begin
      model_reset();
      run = 1;
      do_reset();
      expect_state(1'b0, 1'b0, 1'b1);
      expect_wc(0);

      // Basic word assembly
      cycle(1, 8'h23, 0); cycle(1, 8'h26, 0); cycle(1, 8'h81, 0); cycle(1, 8'h04, 0);
      expect_write(0, 32'h04812623);
      cycle(0, 0, 0);
      expect_wc(1);

      // Termination, then trailing end word ignored
      do_reset();
      send_word(32'h1122_3344);
      send_word(32'h5566_7788);
      send_word(32'hFFFF_FFFF);
      expect_state(1'b1, 1'b0, 1'b0);
      send_word(32'hFFFF_FFFF);
      expect_state(1'b1, 1'b0, 1'b0);
      expect_wc(2);

      // Break discards a partial word
      do_reset();
      cycle(1, 8'h13, 0); cycle(1, 8'h04, 0);
      cycle(1, 8'hEE, 1);
      cycle(1, 8'h13, 0); cycle(1, 8'h04, 0); cycle(1, 8'h01, 0); cycle(1, 8'h05, 0);
      expect_write(0, 32'h05010413);
      cycle(0, 0, 0);
      expect_wc(1);

      // Overflow with four-word memory
      do_reset();
      for (int i = 0; i < 4; i++) begin
         send_word(32'hA000_0000 + i);
         cycle(0, 0, 0);
      end
      send_word(32'h1234_5678);
      expect_state(1'b0, 1'b1, 1'b1);
      expect_wc(4);

      // Reset mid-word
      do_reset();
      cycle(1, 8'h93, 0); cycle(1, 8'h07, 0);
      do_reset();
      cycle(1, 8'h93, 0); cycle(1, 8'h07, 0); cycle(1, 8'h70, 0); cycle(1, 8'hFF, 0);
      expect_write(0, 32'hFF700793);

`ifdef LOADER_TIMEOUT_EN
      do_reset();
      cycle(1, 8'hAA, 0);
      for (int i = 0; i < 101; i++) cycle(0, 0, 0);
      send_word(32'h0403_0201);
      expect_write(0, 32'h04030201);
      cycle(0, 0, 0);
      expect_wc(1);
`endif

      // Randomized streams
      for (int ep = 0; ep < 30; ep++) begin
         do_reset();
         for (int c = 0; c < 150; c++) begin
            logic       v, b;
            logic [7:0] d;
            v = ($urandom % 3) != 0;
            b = ($urandom % 40) == 0;
            d = ((ep % 3 == 0) && c > 60) || ($urandom % 8 == 0) ? 8'hFF : 8'($urandom);
            if ($urandom % 250 == 0) do_reset();
            else cycle(v, d, b);
         end
      end

      cycle(0, 0, 0);
      run = 0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end
endmodule
